// File: rtl/queue_pkg.sv
// ----------------------------------------------------------------------------
// queue_pkg
// Shared constants and helpers for the queue block.
//   QUEUE_DEFAULT_WIDTH : default payload width in bits
//   QUEUE_DEFAULT_DEPTH : default entry count (power of two, >= 2)
//   clog2()             : ceiling log2, used to size pointers and counters
// ----------------------------------------------------------------------------
package queue_pkg;

  localparam int QUEUE_DEFAULT_WIDTH = 14;
  localparam int QUEUE_DEFAULT_DEPTH = 4;

  // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/queue.sv
// ----------------------------------------------------------------------------
// queue
// Circular-buffer FIFO with a level/ack push handshake and an edge-detected
// pop acknowledge.
//
// Ports
//   clock      in   sole clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   write      in   [WIDTH] data to enqueue
//   write_en   in   push request, held by the producer until write_ack
//   write_ack  out  push accepted (registered); clears after write_en drops
//   read       out  [WIDTH] head entry, all-zero when empty (combinational)
//   read_en    out  queue non-empty (combinational)
//   read_ack   in   consumer done with head; a rising edge pops one entry
//   count      out  [clog2(DEPTH+1)] occupancy      (QUEUE_STATUS_EN only)
//   full       out  occupancy == DEPTH              (QUEUE_STATUS_EN only)
//
// Configuration
//   QUEUE_STATUS_EN : when defined, adds the count/full status ports.
// ----------------------------------------------------------------------------
module queue
  import queue_pkg::*;
#(
  parameter int WIDTH = QUEUE_DEFAULT_WIDTH,
  parameter int DEPTH = QUEUE_DEFAULT_DEPTH
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [WIDTH-1:0]            write,
  input  logic                        write_en,
  output logic                        write_ack,
  output logic [WIDTH-1:0]            read,
  output logic                        read_en,
  input  logic                        read_ack
`ifdef QUEUE_STATUS_EN
  ,
  output logic [clog2(DEPTH+1)-1:0]   count,
  output logic                        full
`endif
);

  // DEPTH is a power of two, so PW-bit pointers wrap modulo DEPTH for free.
  localparam int PW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

  localparam logic [CW-1:0] COUNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_ZERO   = {PW{1'b0}};
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);

  // Storage is intentionally left out of reset.
  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] occupancy;
  logic          read_ack_prev;

  logic          not_empty;
  logic          is_full;
  logic          push;
  logic          pop;
  logic          write_ack_next;
  logic [CW-1:0] occupancy_next;
  logic [PW-1:0] head_next;
  logic [PW-1:0] tail_next;

  // Handshake decode: pop on a read_ack rising edge with data present; push
  // on a fresh request when there is room, or when a same-cycle pop frees
  // the slot that tail (== head when full) points at.
  always_comb begin
    not_empty      = (occupancy != COUNT_ZERO);
    is_full        = (occupancy == COUNT_FULL);
    pop            = read_ack & ~read_ack_prev & not_empty;
    push           = write_en & ~write_ack & (~is_full | pop);
    // write_ack latches on acceptance and holds until write_en is released,
    // so one held request produces exactly one push.
    write_ack_next = push | (write_ack & write_en);
  end

  // Next-state for occupancy and pointers.
  always_comb begin
    occupancy_next = occupancy;
    head_next      = head;
    tail_next      = tail;

    case ({push, pop})
      2'b10:   occupancy_next = occupancy + COUNT_ONE;
      2'b01:   occupancy_next = occupancy - COUNT_ONE;
      default: occupancy_next = occupancy;
    endcase

    if (pop) begin
      head_next = head + PTR_ONE;
    end else begin
      head_next = head;
    end

    if (push) begin
      tail_next = tail + PTR_ONE;
    end else begin
      tail_next = tail;
    end
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head          <= PTR_ZERO;
      tail          <= PTR_ZERO;
      occupancy     <= COUNT_ZERO;
      write_ack     <= 1'b0;
      read_ack_prev <= 1'b0;
    end else begin
      head          <= head_next;
      tail          <= tail_next;
      occupancy     <= occupancy_next;
      write_ack     <= write_ack_next;
      read_ack_prev <= read_ack;
    end
  end

  // Storage write at the tail slot on an accepted push.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[tail] <= write;
    end
  end

  // Head presentation; reads as zero when nothing is queued.
  always_comb begin
    read_en = not_empty;
    if (not_empty) begin
      read = mem[head];
    end else begin
      read = {WIDTH{1'b0}};
    end
  end

`ifdef QUEUE_STATUS_EN
  // Status taps straight off the registered occupancy.
  always_comb begin
    count = occupancy;
    full  = is_full;
  end
`endif

endmodule

// File: tb/tb_queue.sv
// ----------------------------------------------------------------------------
// tb_queue
// Self-checking bench for queue (default WIDTH=14, DEPTH=4). A transaction-
// level model (an SV queue of payloads plus the pending-request flag) predicts
// read/read_en/write_ack after every clock edge.
// ----------------------------------------------------------------------------
module tb_queue;

  localparam int W = 14;
  localparam int D = 4;

  logic         clock;
  logic         reset_n;
  logic [W-1:0] write;
  logic         write_en;
  logic         write_ack;
  logic [W-1:0] read;
  logic         read_en;
  logic         read_ack;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [W-1:0] mq[$];
  logic         m_ack;
  logic         m_prev_ack;

  queue #(.WIDTH(W), .DEPTH(D)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .write    (write),
    .write_en (write_en),
    .write_ack(write_ack),
    .read     (read),
    .read_en  (read_en),
    .read_ack (read_ack)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model_head();
    if (mq.size() > 0) return mq[0];
    else return {W{1'b0}};
  endfunction

  // Compare all observable outputs with the model.
  task automatic check_all(input string tag);
    check_val({tag, "_read_en"},   32'(read_en),   32'(mq.size() > 0));
    check_val({tag, "_read"},      32'(read),      32'(model_head()));
    check_val({tag, "_write_ack"}, 32'(write_ack), 32'(m_ack));
  endtask

  // One clock edge: evaluate the rules on the inputs present at the edge,
  // then sample outputs 1 time unit later.
  task automatic tick();
    bit do_pop;
    bit do_push;
    do_pop  = read_ack && !m_prev_ack && (mq.size() > 0);
    do_push = write_en && !m_ack && ((mq.size() < D) || do_pop);
    @(posedge clock);
    if (do_pop) void'(mq.pop_front());
    if (do_push) mq.push_back(write);
    m_ack      = do_push || (m_ack && write_en);
    m_prev_ack = read_ack;
    #1;
  endtask

  task automatic step(input string tag);
    tick();
    check_all(tag);
  endtask

  task automatic push_one(input logic [W-1:0] v, input string tag);
    write    = v;
    write_en = 1'b1;
    step(tag);
    write_en = 1'b0;
    step(tag);
  endtask

  task automatic pop_one(input string tag);
    read_ack = 1'b1;
    step(tag);
    read_ack = 1'b0;
    step(tag);
  endtask

  logic [W-1:0] exp_order [4];
  logic [W-1:0] v;

  initial begin
    reset_n    = 1'b0;
    write      = {W{1'b0}};
    write_en   = 1'b0;
    read_ack   = 1'b0;
    m_ack      = 1'b0;
    m_prev_ack = 1'b0;

    // Reset state.
    #1;
    check_all("reset");
    repeat (3) @(posedge clock);
    #2;
    reset_n = 1'b1;
    check_all("post_reset");

    // Single push held for several cycles gives exactly one entry.
    write    = 14'h00A5;
    write_en = 1'b1;
    step("hold_first");
    check_val("first_ack",  32'(write_ack), 32'd1);
    check_val("first_read", 32'(read),      32'h00A5);
    for (int i = 0; i < 5; i++) step("hold_more");
    write_en = 1'b0;
    step("hold_release");
    pop_one("hold_pop");
    check_val("hold_single_entry", 32'(read_en), 32'd0);

    // Fill to full, blocked request, pop and accept on the same edge.
    for (int i = 1; i <= 4; i++) push_one(W'(i), "fill");
    write    = 14'd5;
    write_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("blocked");
      check_val("blocked_ack", 32'(write_ack), 32'd0);
    end
    read_ack = 1'b1;
    step("pop_push_full");
    check_val("full_swap_read", 32'(read),      32'd2);
    check_val("full_swap_ack",  32'(write_ack), 32'd1);
    read_ack = 1'b0;
    write_en = 1'b0;
    step("full_swap_rel");

    // Drain in order.
    exp_order[0] = 14'd2;
    exp_order[1] = 14'd3;
    exp_order[2] = 14'd4;
    exp_order[3] = 14'd5;
    for (int i = 0; i < 4; i++) begin
      check_val("drain_order", 32'(read), 32'(exp_order[i]));
      pop_one("drain");
    end
    check_val("drained_en",   32'(read_en), 32'd0);
    check_val("drained_read", 32'(read),    32'd0);
    pop_one("extra_pop");
    check_val("extra_pop_en", 32'(read_en), 32'd0);

    // Held read_ack pops only once.
    for (int i = 0; i < 3; i++) push_one(W'($urandom), "three");
    v = mq[1];
    read_ack = 1'b1;
    for (int i = 0; i < 4; i++) step("held_ack");
    read_ack = 1'b0;
    step("held_rel");
    check_val("held_second", 32'(read), 32'(v));
    pop_one("held_drain1");
    pop_one("held_drain2");
    check_val("held_two_left", 32'(read_en), 32'd0);

    // Ten push/pop pairs: pointers wrap twice.
    for (int i = 0; i < 10; i++) begin
      v = W'($urandom);
      push_one(v, "wrap_push");
      check_val("wrap_data", 32'(read), 32'(v));
      pop_one("wrap_pop");
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      if (write_en && write_ack) begin
        write_en = 1'b0;
      end else if (!write_en && ($urandom_range(0, 2) != 0)) begin
        write    = W'($urandom);
        write_en = 1'b1;
      end
      read_ack = 1'($urandom_range(0, 1));
      step("rand");
    end

    // Mid-stream reset with a live handshake.
    read_ack = 1'b0;
    write_en = 1'b0;
    step("pre_rst");
    if (mq.size() == D) pop_one("pre_rst_pop");
    write    = W'($urandom);
    write_en = 1'b1;
    step("pre_rst_push");
    reset_n = 1'b0;
    #1;
    check_val("async_rst_en",  32'(read_en),   32'd0);
    check_val("async_rst_ack", 32'(write_ack), 32'd0);
    mq.delete();
    m_ack      = 1'b0;
    m_prev_ack = 1'b0;
    @(posedge clock);
    #2;
    check_all("in_rst");
    reset_n = 1'b1;
    write   = 14'h1234;
    step("after_rst_push");
    check_val("after_rst_read", 32'(read), 32'h1234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/queue.md
QUEUE -- requirements
Module: queue

Interface
REQ-001 Parameter WIDTH, default 14, payload bit width (first positional parameter).
REQ-002 Parameter DEPTH, default 4, entry count; a power of two, at least 2 (second positional parameter).
REQ-003 Port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port reset_n  input  1  asynchronous active-low reset.
REQ-005 Port write  input  WIDTH  data to enqueue.
REQ-006 Port write_en  input  1  producer push request, held high until write_ack is seen.
REQ-007 Port write_ack  output  1  push accepted; registered.
REQ-008 Port read  output  WIDTH  head entry data.
REQ-009 Port read_en  output  1  queue non-empty; read is valid.
REQ-010 Port read_ack  input  1  consumer done with head entry; pops on its rising edge.

Function
REQ-011 Circular buffer of DEPTH entries with head and tail pointers that wrap modulo DEPTH, plus an occupancy count of 0..DEPTH.
REQ-012 read_en SHALL be combinational: high exactly when count > 0.
REQ-013 read SHALL combinationally equal the head entry when count > 0, and all-zero when empty.
REQ-014 Accept condition: write_en high, write_ack low, and either not full or a pop in the same cycle; the edge stores write at tail and advances tail.
REQ-015 write_ack SHALL rise the cycle after acceptance, stay high while write_en stays high, and clear the cycle after write_en falls. This gives exactly one push per request.
REQ-016 A request blocked by full SHALL stay pending with write_ack low; it is accepted on the first edge where the accept condition holds.
REQ-017 Pop occurs when read_ack is high, its registered previous value is low, and count > 0; head advances by one.
REQ-018 read_ack held high SHALL NOT cause further pops; a rising edge while empty is ignored and not remembered.
REQ-019 Simultaneous push and pop SHALL leave count unchanged. On full, the freed slot is reused. On empty, only the push takes effect.
REQ-020 FIFO order SHALL be preserved across pointer wrap-around.
REQ-021 Latency: a pushed entry is visible on read/read_en in the cycle after the accepting edge.

Reset
REQ-022 When reset_n is low: head=0, tail=0, count=0, write_ack=0, read_ack history=0, read_en=0, read=0. Storage contents are not reset.
REQ-023 Reset mid-handshake discards all contents. A write_en still high after reset is treated as a new request.

Configuration
REQ-024 Macro QUEUE_STATUS_EN defined: add output ports count (width clog2(DEPTH+1), current occupancy) and full (1 bit, count==DEPTH), both combinational from the registered count.
REQ-025 QUEUE_STATUS_EN undefined: these ports do not exist; all other behaviour is identical.

Structure
REQ-026 Package queue_pkg SHALL hold QUEUE_DEFAULT_WIDTH=14 and QUEUE_DEFAULT_DEPTH=4, plus a pointer-width helper function (clog2).
REQ-027 Single flat module; no sub-module; storage is an inferred register array.

Verification
REQ-028 After reset, hold write_en with write=14'h0A5 -> write_ack high on the next edge, read_en=1, read=14'h0A5; write_en held for 5 more cycles -> count stays 1.
REQ-029 Push 1,2,3,4 with DEPTH=4; push 5 -> write_ack stays low (full). Pulse read_ack -> read=2, and 5 is accepted on that same edge.
REQ-030 Pop all entries with single-cycle read_ack pulses -> order 2,3,4,5; then read_en=0 and read=0. An extra read_ack pulse leaves count=0.
REQ-031 Hold read_ack high 4 cycles with 3 entries queued -> exactly one pop, count=2.
REQ-032 Run 10 push/pop pairs so the pointers wrap twice -> data out equals data in. Assert reset_n low mid-stream -> read_en=0 and write_ack=0 immediately, without waiting for a clock edge.
